// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - HI/LO multiply/divide sequencing controller
// Owns HI/LO, launches the divide core or pipelined multiplier, drains the core after reset.
module md_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic [2:0]  i_req_op,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  output logic        o_req_ready,
  input  logic        i_flush,
  output logic [31:0] o_rd_data,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_div_start,
  output logic        o_div_sign,
  output logic [31:0] o_div_a,
  output logic [31:0] o_div_b,
  input  logic        i_div_busy,
  input  logic [63:0] i_div_result,
  output logic        o_mul_sign,
  output logic [31:0] o_mul_a,
  output logic [31:0] o_mul_b,
  input  logic [63:0] i_mul_result,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_DIV_LAUNCH,
    S_DIV_RUN,
    S_DIV_CAPT,
    S_MUL_RUN
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_t      r_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic        r_sign;
  logic        r_div_start;
  logic        r_kill;
  logic [3:0]  r_cnt;

  logic w_accept;
  logic w_kill;

  assign w_accept = i_req_valid & ~i_flush & (r_state == S_IDLE);
  // A flush in the completion cycle itself still discards the result.
  assign w_kill   = r_kill | i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_DRAIN;
      r_hi        <= '0;
      r_lo        <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_sign      <= 1'b0;
      r_div_start <= 1'b0;
      r_kill      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_div_start <= 1'b0;
      case (r_state)
        S_DRAIN: begin
          if (!i_div_busy) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (w_accept) begin
            case (i_req_op)
              3'd0, 3'd1: begin
                r_op_a  <= i_req_a;
                r_op_b  <= i_req_b;
                r_sign  <= ~i_req_op[0];
                r_cnt   <= CNT_INIT;
                r_state <= S_MUL_RUN;
              end
              3'd2, 3'd3: begin
                r_op_a      <= i_req_a;
                r_op_b      <= i_req_b;
                r_sign      <= ~i_req_op[0];
                r_div_start <= 1'b1;
                r_state     <= S_DIV_LAUNCH;
              end
              3'd4:    r_hi <= i_req_a;
              3'd5:    r_lo <= i_req_a;
              default: ;
            endcase
          end
        end
        S_DIV_LAUNCH: begin
          // Core raises Busy one cycle after start, so Busy is not trusted here.
          if (i_flush) r_kill <= 1'b1;
          r_state <= S_DIV_RUN;
        end
        S_DIV_RUN: begin
          if (i_flush) r_kill <= 1'b1;
          if (!i_div_busy) r_state <= S_DIV_CAPT;
        end
        S_DIV_CAPT: begin
          if (!w_kill) {r_hi, r_lo} <= i_div_result;
          r_kill  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_MUL_RUN: begin
          if (r_cnt == 4'd0) begin
            if (!w_kill) {r_hi, r_lo} <= i_mul_result;
            r_kill  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (i_flush) r_kill <= 1'b1;
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_DRAIN;
      endcase
    end
  end

  assign o_req_ready = w_accept;
  assign o_rd_data   = (i_req_op == 3'd6) ? r_hi : r_lo;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;
  assign o_div_start = r_div_start;
  assign o_div_sign  = r_sign;
  assign o_div_a     = r_op_a;
  assign o_div_b     = r_op_b;
  assign o_mul_sign  = r_sign;
  assign o_mul_a     = r_op_a;
  assign o_mul_b     = r_op_b;
  assign o_busy      = (r_state != S_IDLE);

endmodule
